regfile_mp: RTL

- Parametrised multi-port register file for the pipelined datapath.
- Provides NUM_RD combinational read ports and NUM_WR synchronous write ports, with write-to-read bypass and an optional hardwired zero register.
- Holds a per-entry pending (scoreboard) bit that the hazard unit sets at issue and writeback clears.
- A sequential clear engine zeroes the whole file on request without asserting reset.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_mp.sv | 122 ++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
package regfile_pkg;

   // Clear-sweep FSM state encoding
   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StSweep = 2'd1,
      StDone  = 2'd2
   } clr_state_e;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefDepth = 32;

   // Low bit of field idx in a flattened bus of w-bit fields; used to pack and unpack port slices
   function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
      return idx * w;
   endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once and zeroes it, then pulses done.
module regfile_clear_fsm
   import regfile_pkg::*;
#(
   parameter int unsigned DEPTH = DefDepth,
   parameter int unsigned AW    = 5
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear_req,
   output logic          clear_busy,
   output logic          clear_done,
   output logic          sweep_en,
   output logic [AW-1:0] sweep_addr
);

   localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);

   clr_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   // State and sweep counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state: requests only accepted when idle; exit after the last entry is written
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (clear_req) begin
               state_d = StSweep;
               cnt_d   = '0;
            end
         end
         StSweep: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == LastAddr) begin
               state_d = StDone;
            end
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Outputs decoded from the current state
   always_comb begin
      clear_busy = (state_q != StIdle);
      clear_done = (state_q == StDone);
      sweep_en   = (state_q == StSweep);
      sweep_addr = cnt_q;
   end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write-to-read bypass, optional zero register,
// per-entry pending scoreboard and a sequential clear engine.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = DefWidth,
   parameter int unsigned DEPTH    = DefDepth,
   parameter int unsigned AW       = 5,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned NUM_WR   = 2,
   parameter int unsigned ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*AW-1:0]     rd_addr,
   output logic [NUM_RD*WIDTH-1:0]  rd_data,
   output logic [NUM_RD-1:0]        rd_ready,
   input  logic [NUM_WR-1:0]        wr_en,
   input  logic [NUM_WR*AW-1:0]     wr_addr,
   input  logic [NUM_WR*WIDTH-1:0]  wr_data,
   input  logic                     issue_en,
   input  logic [AW-1:0]            issue_addr,
   input  logic                     clear_req,
   output logic                     clear_busy,
   output logic                     clear_done
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] pend_q, pend_d;
   logic             sweep_en;
   logic [AW-1:0]    sweep_addr;

   function automatic logic is_zero_addr(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   regfile_clear_fsm #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_clear_fsm (
      .clk        (clk),
      .rst        (rst),
      .clear_req  (clear_req),
      .clear_busy (clear_busy),
      .clear_done (clear_done),
      .sweep_en   (sweep_en),
      .sweep_addr (sweep_addr)
   );

   // Array storage: sweep has priority; later write ports override earlier ones on collision
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (sweep_en) begin
         mem_q[sweep_addr] <= '0;
      end else if (!clear_busy) begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w] && !is_zero_addr(wr_addr[slice_lo(w, AW) +: AW])) begin
               mem_q[wr_addr[slice_lo(w, AW) +: AW]] <= wr_data[slice_lo(w, WIDTH) +: WIDTH];
            end
         end
      end
   end

   // Scoreboard next state: writeback clears, issue sets afterwards so a new producer wins
   always_comb begin
      pend_d = pend_q;
      if (sweep_en) begin
         pend_d[sweep_addr] = 1'b0;
      end else if (!clear_busy) begin
         for (int unsigned w = 0; w < NUM_WR; w++) begin
            if (wr_en[w]) begin
               pend_d[wr_addr[slice_lo(w, AW) +: AW]] = 1'b0;
            end
         end
         if (issue_en && !is_zero_addr(issue_addr)) begin
            pend_d[issue_addr] = 1'b1;
         end
      end
   end

   // Scoreboard register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [AW-1:0]    ra;
      logic [WIDTH-1:0] data;
      logic             ready;

      assign ra = rd_addr[slice_lo(p, AW) +: AW];

      // Read mux: array, then same-cycle write bypass (highest port last), zero register on top
      always_comb begin
         data  = mem_q[ra];
         ready = !pend_q[ra];
         if (!clear_busy) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
               if (wr_en[w] && (wr_addr[slice_lo(w, AW) +: AW] == ra)) begin
                  data  = wr_data[slice_lo(w, WIDTH) +: WIDTH];
                  ready = 1'b1;
               end
            end
         end
         if (is_zero_addr(ra)) begin
            data  = '0;
            ready = 1'b1;
         end
      end

      assign rd_data[slice_lo(p, WIDTH) +: WIDTH] = data;
      assign rd_ready[p]                          = ready;
   end

endmodule
